// File: rtl/sad_result_serializer.sv
// sad_result_serializer: buffers 92-bit signed SAD results in a small circular
// FIFO and streams each one out as six 16-bit beats (LSB beat first) over a
// valid/ready bus. The upstream core cannot be stalled, so a result that
// arrives with no free slot is dropped and latched into a sticky overflow flag.
module sad_result_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [91:0]        in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [15:0]               out_data,
  output logic                      out_last,
  output logic                      full,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int DATA_W    = 92;
  localparam int BEAT_W    = 16;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam logic [2:0] LAST_BEAT = 3'd5;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wp;
  logic [AW-1:0]            rp;
  logic [2:0]               beat;
  logic                     hs;
  logic                     pop;
  logic                     wr;
  logic                     has_room;

  // Sign-extend the stored result to six full beats and pick beat b.
  function automatic logic [BEAT_W-1:0] beat_slice(
    input logic signed [DATA_W-1:0] w,
    input logic [2:0]               b
  );
    logic signed [95:0] ext;
    ext = {{4{w[DATA_W-1]}}, w};
    case (b)
      3'd0:    beat_slice = ext[15:0];
      3'd1:    beat_slice = ext[31:16];
      3'd2:    beat_slice = ext[47:32];
      3'd3:    beat_slice = ext[63:48];
      3'd4:    beat_slice = ext[79:64];
      3'd5:    beat_slice = ext[95:80];
      default: beat_slice = '0;
    endcase
  endfunction

  // Read-side outputs decode from registered state only; the bus is forced to
  // zero whenever nothing is presented.
  always_comb begin
    out_valid = (count != '0);
    out_last  = out_valid && (beat == LAST_BEAT);
    out_data  = out_valid ? beat_slice(mem[rp], beat) : '0;
    full      = (count == DEPTH_C);
  end

  // Handshake, pop and write-acceptance decisions for the coming edge. A pop
  // on the final beat frees a slot, so a full FIFO still accepts that cycle.
  always_comb begin
    hs       = out_valid && out_ready;
    pop      = hs && (beat == LAST_BEAT);
    has_room = (count < DEPTH_C);
    wr       = in_valid && (has_room || pop);
  end

  // Result storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp] <= in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  // Beat counter advances only on a handshake and wraps after the last beat,
  // so a stalled beat holds and results never interleave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (hs) begin
      beat <= (beat == LAST_BEAT) ? 3'd0 : beat + 3'd1;
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid && !wr) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sad_result_serializer.sv
// Testbench for sad_result_serializer: table of hand-computed beat vectors,
// plus sequences for back-to-back, sustained rate, overflow, stall, full with
// simultaneous pop, and mid-frame reset. Expected beats go into a queue when a
// result is driven and are popped on every handshake.
module tb_sad_result_serializer;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [91:0] in_data = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic [15:0]        out_data;
  logic               out_last;
  logic               full;
  logic               overflow;
  logic [$clog2(DEPTH):0] count;

  sad_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .full      (full),
    .overflow  (overflow),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [91:0]       din;
    logic [5:0][15:0]  b;   // b[0] is the first beat
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;
  logic [16:0] expq[$];     // {last, data}
  logic        stall_prev = 1'b0;
  logic [15:0] stall_d = '0;
  logic        stall_l = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mbeat(input logic [91:0] w, input int b);
    logic [95:0] e;
    e = {{4{w[91]}}, w};
    return e[16*b +: 16];
  endfunction

  function automatic logic [91:0] rnd92();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[91:0];
  endfunction

  task automatic push_word(input logic [91:0] w);
    for (int b = 0; b < 6; b++) expq.push_back({(b == 5), mbeat(w, b)});
  endtask

  // Check outputs at the falling edge, then advance one clock.
  task automatic tick();
    logic [16:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          e = expq.pop_front();
          chk("beat_data", out_data, e[15:0]);
          chk("beat_last", out_last, e[16]);
        end
      end
      if (stall_prev && out_valid) begin
        chk("stall_data", out_data, stall_d);
        chk("stall_last", out_last, stall_l);
      end
      if (!out_valid) chk("idle_bus", {out_last, out_data}, 0);
      stall_prev = out_valid && !out_ready;
      stall_d    = out_data;
      stall_l    = out_last;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [91:0] w, input bit accept);
    in_data  = w;
    in_valid = 1'b1;
    if (accept) push_word(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int limit, output int n);
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < limit) begin
      tick();
      n++;
    end
    if (expq.size() != 0 || out_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: pending=%0d expected 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tv [5];
    logic [91:0] w;
    logic [91:0] ow [5];
    int          n;

    tv[0].din = 92'd1;
    tv[0].b   = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    tv[1].din = '1;
    tv[1].b   = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tv[2].din = {1'b1, 91'd0};
    tv[2].b   = {16'hF800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tv[3].din = 92'h123456789ABCDEF01234567;
    tv[3].b   = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0123, 16'h4567};
    tv[4].din = 92'hFEDCBA9876543210FEDCBA9;
    tv[4].b   = {16'hFFED, 16'hCBA9, 16'h8765, 16'h4321, 16'h0FED, 16'hCBA9};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;

    // Table: single results, latency and six-cycle frame
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data  = tv[i].din;
      in_valid = 1'b1;
      for (int b = 0; b < 6; b++) expq.push_back({(b == 5), tv[i].b[b]});
      tick();
      in_valid = 1'b0;
      chk("latency_valid", out_valid, 1);
      chk("latency_first", out_data, tv[i].b[0]);
      drain("vec", 20, n);
      chk("vec_cycles", n, 6);
      chk("vec_count", count, 0);
    end

    // Back-to-back: no bubble between frames
    send(rnd92(), 1);
    tick();
    tick();
    send(rnd92(), 1);
    drain("b2b", 30, n);
    chk("b2b_cycles", n, 9);

    // Sustained one result per six cycles
    for (int k = 0; k < 8; k++) begin
      send(rnd92(), 1);
      repeat (5) tick();
    end
    drain("sustain", 20, n);
    chk("sustain_overflow", overflow, 0);

    // Overflow: fifth result dropped while stalled
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) ow[k] = rnd92();
    for (int k = 0; k < 5; k++) begin
      send(ow[k], k < 4);
      if (k == 2) chk("ovf_full_early", full, 0);
      if (k == 3) begin
        chk("ovf_full", full, 1);
        chk("ovf_count4", count, 4);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    out_ready = 1'b1;
    drain("ovf", 40, n);
    chk("ovf_cycles", n, 24);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // Stall stability with out_ready toggling every cycle
    hs_cnt    = 0;
    out_ready = 1'b0;
    send(rnd92(), 1);
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 40) begin
      out_ready = !out_ready;
      tick();
      n++;
    end
    if (expq.size() != 0 || out_valid) begin
      total++;
      bad++;
      $display("FAIL stall_timeout: pending=%0d expected 0", expq.size());
      expq.delete();
    end
    chk("stall_handshakes", hs_cnt, 6);

    // Full FIFO with a write on the final-beat handshake
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(rnd92(), 1);
    chk("fp_full", full, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("fp_at_last", out_last, 1);
    send(rnd92(), 1);
    chk("fp_count", count, 4);
    chk("fp_full_after", full, 1);
    chk("fp_overflow", overflow, 0);
    drain("fp", 40, n);
    chk("fp_cycles", n, 24);

    // Mid-frame asynchronous reset
    out_ready = 1'b1;
    send(rnd92(), 1);
    repeat (3) tick();
    chk("mr_before", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_count", count, 0);
    chk("mr_overflow", overflow, 0);
    chk("mr_data", out_data, 0);
    expq.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mr_idle", out_valid, 0);
    end
    w = rnd92();
    send(w, 1);
    chk("mr_new_beat0", out_data, mbeat(w, 0));
    drain("mr", 20, n);
    chk("mr_cycles", n, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
